// File: rtl/mmio_console_master.sv
`default_nettype none
// ============================================================================
// Module      : mmio_console_master
// Description : Bus initiator for a memory-mapped console. Drains a small
//               character FIFO into the PRINT register, forwards an exit
//               code to the EXIT register (terminal), and optionally reads
//               a cycle counter from the EXIT address.
//               Optional feature macro: MMIO_CONSOLE_CYCLE_READ_EN enables
//               the cycle-count read path.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_console_master #(
    parameter logic [31:0] MMIO_ADDR  = 32'h8000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    // character input stream
    input  logic        char_valid_i,
    input  logic [7:0]  char_data_i,
    output logic        char_ready_o,
    // exit request
    input  logic        exit_valid_i,
    input  logic [31:0] exit_code_i,
    output logic        exit_ready_o,
    // cycle-count read
    input  logic        cyc_req_i,
    output logic        cyc_valid_o,
    output logic [31:0] cyc_data_o,
    // core-side data bus
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i,
    // status
    output logic        busy_o
);

    localparam int unsigned     c_PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [c_PTR_W:0] c_FULL_CNT = FIFO_DEPTH[c_PTR_W:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        K_CHAR = 2'd0,
        K_EXIT = 2'd1,
        K_CYC  = 2'd2
    } kind_e;

    state_e              state_q, state_d;
    kind_e               kind_q, kind_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                we_q, we_d;
    logic [3:0]          be_q, be_d;

    logic [7:0]          fifo_q [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  wptr_q, rptr_q;
    logic [c_PTR_W:0]    count_q;

    logic                w_full, w_empty, w_push, w_pop, w_rsp_done, w_cyc_sel;

    assign w_full       = (count_q == c_FULL_CNT);
    assign w_empty      = (count_q == '0);
    assign w_rsp_done   = (state_q == RSP) && data_rvalid_i;
    assign w_pop        = w_rsp_done && (kind_q == K_CHAR);
    // Gated by rst_ni so the output is low while reset is held, even though
    // the FIFO is empty then.
    assign char_ready_o = rst_ni && !w_full && (state_q != DONE);
    assign w_push       = char_valid_i && char_ready_o;

`ifdef MMIO_CONSOLE_CYCLE_READ_EN
    assign w_cyc_sel = cyc_req_i;
`else
    logic w_unused;
    assign w_cyc_sel = 1'b0;
    assign w_unused  = cyc_req_i ^ (^data_rdata_i);
`endif

    // Next-state and bus-field selection; fields are latched in IDLE only
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (w_cyc_sel) begin
                    kind_d  = K_CYC;
                    addr_d  = MMIO_ADDR;
                    we_d    = 1'b0;
                    be_d    = 4'hF;
                    wdata_d = '0;
                    state_d = REQ;
                end else if (!w_empty) begin
                    kind_d  = K_CHAR;
                    addr_d  = MMIO_ADDR + 32'd4;
                    we_d    = 1'b1;
                    be_d    = 4'b0001;
                    wdata_d = {24'h0, fifo_q[rptr_q]};
                    state_d = REQ;
                end else if (exit_valid_i) begin
                    kind_d  = K_EXIT;
                    addr_d  = MMIO_ADDR;
                    we_d    = 1'b1;
                    be_d    = 4'hF;
                    wdata_d = exit_code_i;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (data_gnt_i) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                if (data_rvalid_i) begin
                    state_d = (kind_q == K_EXIT) ? DONE : IDLE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and latched bus fields
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            kind_q  <= K_CHAR;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
        end
    end

    // FIFO storage; contents need no reset since the count gates them
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            fifo_q[wptr_q] <= char_data_i;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (w_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (w_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef MMIO_CONSOLE_CYCLE_READ_EN
    logic        cyc_valid_q;
    logic [31:0] cyc_data_q;

    // Capture the read data and flag it for exactly one cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cyc_valid_q <= 1'b0;
            cyc_data_q  <= '0;
        end else begin
            cyc_valid_q <= w_rsp_done && (kind_q == K_CYC);
            if (w_rsp_done && (kind_q == K_CYC)) begin
                cyc_data_q <= data_rdata_i;
            end
        end
    end

    assign cyc_valid_o = cyc_valid_q;
    assign cyc_data_o  = cyc_data_q;
`else
    assign cyc_valid_o = 1'b0;
    assign cyc_data_o  = '0;
`endif

    assign data_req_o   = (state_q == REQ);
    assign data_addr_o  = addr_q;
    assign data_we_o    = we_q;
    assign data_be_o    = be_q;
    assign data_wdata_o = wdata_q;
    assign exit_ready_o = w_rsp_done && (kind_q == K_EXIT);
    assign busy_o       = !w_empty || (state_q == REQ) || (state_q == RSP);

endmodule
`default_nettype wire

// File: tb/tb_mmio_console_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_console_master
// Description : Scoreboard bench for mmio_console_master. Expected bus
//               transactions, cycle-read results and exit pulses are queued
//               by the stimulus; a monitor pops and compares them.
//               Honours MMIO_CONSOLE_CYCLE_READ_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_console_master;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = '0;
    logic        char_ready_o;
    logic        exit_valid = 1'b0;
    logic [31:0] exit_code = '0;
    logic        exit_ready_o;
    logic        cyc_req = 1'b0;
    logic        cyc_valid_o;
    logic [31:0] cyc_data_o;
    logic        data_req_o;
    logic        data_gnt_i = 1'b0;
    logic        data_rvalid_i = 1'b0;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic [31:0] data_rdata_i = '0;
    logic        busy_o;

    always #5 clk = ~clk;

    mmio_console_master #(
        .MMIO_ADDR  (BASE),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .char_valid_i  (char_valid),
        .char_data_i   (char_data),
        .char_ready_o  (char_ready_o),
        .exit_valid_i  (exit_valid),
        .exit_code_i   (exit_code),
        .exit_ready_o  (exit_ready_o),
        .cyc_req_i     (cyc_req),
        .cyc_valid_o   (cyc_valid_o),
        .cyc_data_o    (cyc_data_o),
        .data_req_o    (data_req_o),
        .data_gnt_i    (data_gnt_i),
        .data_rvalid_i (data_rvalid_i),
        .data_we_o     (data_we_o),
        .data_be_o     (data_be_o),
        .data_addr_o   (data_addr_o),
        .data_wdata_o  (data_wdata_o),
        .data_rdata_i  (data_rdata_i),
        .busy_o        (busy_o)
    );

    // -------------------------------------------------------------- model --
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] cyc_exp_q[$];
    int          exit_exp = 0;
    int          cyc_seen = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    bit          rnd_timing = 1'b0;
    bit          gnt_hold = 1'b0;
    bit          spur_en = 1'b0;
    bit          rd_out = 1'b0;
    logic [31:0] cyc_val = 32'h0000_01F4;

    function automatic txn_t char_txn(input logic [7:0] c);
        char_txn = '{addr: BASE + 32'd4, we: 1'b1, be: 4'b0001, wdata: {24'h0, c}};
    endfunction

    function automatic txn_t exit_txn(input logic [31:0] code);
        exit_txn = '{addr: BASE, we: 1'b1, be: 4'hF, wdata: code};
    endfunction

    function automatic txn_t cyc_txn();
        cyc_txn = '{addr: BASE, we: 1'b0, be: 4'hF, wdata: 32'h0};
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------- responder --
    initial begin : responder
        bit pend;
        int dly;
        pend = 1'b0;
        dly  = 0;
        forever begin
            @(negedge clk);
            if (data_rvalid_i) begin
                data_rvalid_i = 1'b0;
                pend = 1'b0;
            end
            if (data_gnt_i) begin
                data_gnt_i = 1'b0;
                pend = 1'b1;
                dly  = rnd_timing ? int'($urandom_range(0, 2)) : 0;
            end
            if (!rst_n) begin
                pend = 1'b0;
            end else if (pend) begin
                if (dly == 0) begin
                    data_rvalid_i = 1'b1;
                    if (rd_out) begin
                        data_rdata_i = cyc_val;
                        cyc_exp_q.push_back(cyc_val);
                        rd_out = 1'b0;
                    end else begin
                        data_rdata_i = $urandom;
                    end
                end else begin
                    dly--;
                end
            end else if (spur_en && $urandom_range(0, 3) == 0) begin
                data_rvalid_i = 1'b1;
                data_rdata_i  = $urandom;
            end
            if (rst_n && data_req_o && !gnt_hold && (!rnd_timing || $urandom_range(0, 1) == 1)) begin
                data_gnt_i = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------ monitor --
    initial begin : monitor
        txn_t t;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (data_req_o) begin
                    if (exp_q.size() == 0) begin
                        chk("bus_unexpected_req", 72'(data_req_o), 72'h0);
                    end else begin
                        t = exp_q[0];
                        chk("bus_fields", 72'({data_addr_o, data_we_o, data_be_o, data_wdata_o}), 72'(t));
                        if (data_gnt_i) begin
                            void'(exp_q.pop_front());
                            if (!t.we) rd_out = 1'b1;
                        end
                    end
                end
                if (cyc_valid_o) begin
                    cyc_seen++;
                    if (cyc_exp_q.size() == 0) begin
                        chk("cyc_unexpected_valid", 72'(cyc_valid_o), 72'h0);
                    end else begin
                        chk("cyc_data", 72'(cyc_data_o), 72'(cyc_exp_q.pop_front()));
                    end
                end
                if (exit_ready_o) begin
                    if (exit_exp == 0) begin
                        chk("exit_unexpected_pulse", 72'(exit_ready_o), 72'h0);
                    end else begin
                        exit_exp--;
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------- stimulus --
    // All tasks are entered and left at a falling edge.
    task automatic push_char(input logic [7:0] c, input bit rec);
        int i;
        char_valid = 1'b1;
        char_data  = c;
        i = 0;
        while (!char_ready_o && i < 300) begin
            @(negedge clk);
            i++;
        end
        if (!char_ready_o) begin
            chk("push_timeout", 72'(char_ready_o), 72'h1);
        end else if (rec) begin
            exp_q.push_back(char_txn(c));
        end
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || cyc_exp_q.size() != 0 || exit_exp != 0 || busy_o) && i < 2000) begin
            @(negedge clk);
            i++;
        end
        chk(name, 72'({exp_q.size() == 0, cyc_exp_q.size() == 0, exit_exp == 0, busy_o}), 72'hE);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        char_valid = 1'b0;
        cyc_req    = 1'b0;
        exit_valid = 1'b0;
        gnt_hold   = 1'b0;
        spur_en    = 1'b0;
        rd_out     = 1'b0;
        exp_q.delete();
        cyc_exp_q.delete();
        exit_exp = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_release", 72'(char_ready_o), 72'h1);
        @(negedge clk);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [7:0]  c;
        logic [7:0]  b1, b2;
        logic [31:0] code;
        int          i;

        // reset state
        @(negedge clk);
        chk("rst_outputs", 72'({data_req_o, char_ready_o, exit_ready_o, cyc_valid_o, busy_o}), 72'h0);
        chk("rst_bus", 72'({data_addr_o, data_we_o, data_be_o, data_wdata_o}), 72'h0);
        chk("rst_cyc_data", 72'(cyc_data_o), 72'h0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_release", 72'(char_ready_o), 72'h1);
        @(negedge clk);

        // "Hi" with immediate grant and response
        push_char(8'h48, 1'b1);
        push_char(8'h69, 1'b1);
        wait_drain("drain_hi");

        // random characters, random bus timing, spurious responses
        rnd_timing = 1'b1;
        spur_en    = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
            push_char(8'($urandom), 1'b1);
        end
        wait_drain("drain_random");
        repeat (20) @(negedge clk);
        chk("idle_spurious_busy", 72'({busy_o, data_req_o}), 72'h0);
        spur_en    = 1'b0;
        rnd_timing = 1'b0;

        // back-pressure: grant withheld, FIFO fills behind the head
        gnt_hold = 1'b1;
        for (int k = 0; k < 4; k++) push_char(8'h30 + 8'(k), 1'b1);
        repeat (3) begin
            chk("full_ready_low", 72'({char_ready_o, data_req_o, busy_o}), 72'h3);
            @(negedge clk);
        end
        gnt_hold = 1'b0;
        push_char(8'h34, 1'b1);
        wait_drain("drain_full");

        // cycle read takes priority over queued characters
        gnt_hold = 1'b1;
        c  = 8'($urandom);
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        push_char(c, 1'b1);
        push_char(b1, 1'b0);
        push_char(b2, 1'b0);
        cyc_req = 1'b1;
        cyc_seen = 0;
        repeat (2) @(negedge clk);
`ifdef MMIO_CONSOLE_CYCLE_READ_EN
        exp_q.push_back(cyc_txn());
`endif
        exp_q.push_back(char_txn(b1));
        exp_q.push_back(char_txn(b2));
        gnt_hold = 1'b0;
`ifdef MMIO_CONSOLE_CYCLE_READ_EN
        i = 0;
        while (!cyc_valid_o && i < 200) begin
            @(negedge clk);
            i++;
        end
        cyc_req = 1'b0;
        wait_drain("drain_cyc");
        chk("cyc_pulse_count", 72'(cyc_seen), 72'h1);
`else
        wait_drain("drain_cyc");
        cyc_req = 1'b0;
        chk("cyc_pulse_count", 72'(cyc_seen), 72'h0);
        chk("cyc_data_tied", 72'(cyc_data_o), 72'h0);
`endif

        // exit code 0 with two characters queued
        gnt_hold = 1'b1;
        push_char(8'h41, 1'b1);
        push_char(8'h42, 1'b1);
        exit_code  = 32'h0;
        exit_valid = 1'b1;
        exp_q.push_back(exit_txn(32'h0));
        exit_exp = 1;
        gnt_hold = 1'b0;
        i = 0;
        while (exit_exp != 0 && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk("exit_pulse_seen", 72'(exit_exp), 72'h0);
        // DONE is terminal: all requests ignored
        char_valid = 1'b1;
        char_data  = 8'h5A;
        cyc_req    = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("done_quiet", 72'({char_ready_o, data_req_o, busy_o, exit_ready_o}), 72'h0);
        end
        chk("done_no_bus", 72'(exp_q.size()), 72'h0);

        // reset while a request is pending
        do_reset();
        gnt_hold = 1'b1;
        push_char(8'h77, 1'b1);
        push_char(8'h78, 1'b1);
        i = 0;
        while (!data_req_o && i < 50) begin
            @(negedge clk);
            i++;
        end
        chk("req_before_reset", 72'(data_req_o), 72'h1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", 72'({data_req_o, char_ready_o, exit_ready_o, cyc_valid_o, busy_o}), 72'h0);
        chk("async_rst_bus", 72'({data_addr_o, data_we_o, data_be_o, data_wdata_o}), 72'h0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        gnt_hold = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("ready_after_abort", 72'(char_ready_o), 72'h1);
        repeat (10) @(negedge clk);
        chk("no_retry", 72'({busy_o, data_req_o}), 72'h0);

        // random characters followed by a random exit code
        rnd_timing = 1'b1;
        spur_en    = 1'b1;
        for (int k = 0; k < 10; k++) push_char(8'($urandom), 1'b1);
        code       = $urandom;
        exit_code  = code;
        exit_valid = 1'b1;
        exp_q.push_back(exit_txn(code));
        exit_exp = 1;
        wait_drain("drain_exit_random");
        exit_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("final_done", 72'({char_ready_o, data_req_o}), 72'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
